rs232_packet_rx: RTL and testbench



---
 rtl/rs232_packet_rx.sv | 212 +++++++++++++++++++++
 tb/tb_rs232_packet_rx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_packet_rx.sv
// rs232_packet_rx: 8N1 UART receiver plus packet framer.
// Verified packets are released as a ready/valid byte stream.
module rs232_packet_rx #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int MAX_LEN = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       rxd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       chk_err,
  output logic       len_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [7:0]    MAXL    = 8'(MAX_LEN);
  localparam logic [7:0]    SYNC    = 8'h7E;

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } ustate_t;

  typedef enum logic [2:0] {
    P_HUNT, P_CMD, P_LEN, P_PAY, P_CHK, P_DRAIN
  } pstate_t;

  logic          rx_m, rx_s, rx_prev;
  ustate_t       u_st, u_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick, bd, frm_evt;

  pstate_t       p_st, p_nxt;
  logic [7:0]    idx, chk;
  logic          chk_evt, len_evt;
  logic          drain, hs, last_idx;
  logic [7:0]    mem [2**AW];

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rxd;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign tick = (cnt == '0);

  // UART state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) u_st <= U_IDLE;
    else                u_st <= u_nxt;
  end

  // UART next state, byte completion and stop-bit check
  always_comb begin
    u_nxt   = u_st;
    bd      = 1'b0;
    frm_evt = 1'b0;
    case (u_st)
      U_IDLE:
        if (rx_prev && !rx_s) u_nxt = U_START;
      U_START:
        if (tick) u_nxt = rx_s ? U_IDLE : U_DATA;
      U_DATA:
        if (tick && bit_cnt == 3'd7) u_nxt = U_STOP;
      U_STOP:
        if (tick) begin
          u_nxt   = U_IDLE;
          bd      = rx_s;
          frm_evt = !rx_s;
        end
      default: u_nxt = U_IDLE;
    endcase
  end

  // Bit timer and LSB-first shift register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (u_st == U_IDLE) begin
        cnt     <= HALF_M1;
        bit_cnt <= '0;
      end else if (tick) begin
        cnt <= DIV_M1;
      end else begin
        cnt <= cnt - CW'(1);
      end
      if (u_st == U_DATA && tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign drain     = (p_st == P_DRAIN);
  assign last_idx  = (out_len == 8'd0) || (idx == out_len - 8'd1);
  assign out_valid = drain;
  assign out_last  = drain && last_idx;
  assign out_data  = (drain && out_len != 8'd0) ? mem[idx[AW-1:0]] : 8'h00;
  assign hs        = out_valid && out_ready;

  // Parser state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) p_st <= P_HUNT;
    else                p_st <= p_nxt;
  end

  // Parser next state and error events
  always_comb begin
    p_nxt   = p_st;
    chk_evt = 1'b0;
    len_evt = 1'b0;
    case (p_st)
      P_HUNT:
        if (bd && shreg == SYNC) p_nxt = P_CMD;
      P_CMD:
        if (bd) p_nxt = P_LEN;
      P_LEN:
        if (bd) begin
          if (shreg > MAXL) begin
            len_evt = 1'b1;
            p_nxt   = P_HUNT;
          end else begin
            p_nxt = (shreg == 8'd0) ? P_CHK : P_PAY;
          end
        end
      P_PAY:
        if (bd && idx == out_len - 8'd1) p_nxt = P_CHK;
      P_CHK:
        if (bd) begin
          if (shreg == chk) begin
            p_nxt = P_DRAIN;
          end else begin
            chk_evt = 1'b1;
            p_nxt   = P_HUNT;
          end
        end
      P_DRAIN:
        if (hs && last_idx) p_nxt = P_HUNT;
      default: p_nxt = P_HUNT;
    endcase
    if (frm_evt && !drain) p_nxt = P_HUNT;
  end

  // Header capture, checksum, index and registered pulses
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_cmd   <= '0;
      out_len   <= '0;
      chk       <= '0;
      idx       <= '0;
      chk_err   <= 1'b0;
      len_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      chk_err   <= chk_evt;
      len_err   <= len_evt;
      frame_err <= frm_evt;
      overrun   <= drain && (bd || frm_evt);
      if (bd) begin
        case (p_st)
          P_CMD: begin
            out_cmd <= shreg;
            chk     <= shreg;
          end
          P_LEN:
            if (!len_evt) begin
              out_len <= shreg;
              chk     <= chk ^ shreg;
              idx     <= '0;
            end
          P_PAY: begin
            chk <= chk ^ shreg;
            idx <= idx + 8'd1;
          end
          P_CHK: idx <= '0;
          default: ;
        endcase
      end
      if (hs) idx <= idx + 8'd1;
    end
  end

  // Payload buffer write port
  always_ff @(posedge clk_clk) begin
    if (bd && p_st == P_PAY) mem[idx[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_rs232_packet_rx.sv
// tb_rs232_packet_rx: directed packet scenarios for rs232_packet_rx.
// Serial line runs at 16 clocks per bit to keep runs short.
module tb_rs232_packet_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [7:0] out_cmd;
  logic [7:0] out_len;
  logic       chk_err, len_err, frame_err, overrun;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] c;
    logic [7:0] n;
  } beat_t;

  beat_t bq[$];
  int checks = 0;
  int errors = 0;
  int chk_cnt = 0, len_cnt = 0, frm_cnt = 0, ovr_cnt = 0;
  int vcnt = 0, stab_err = 0;
  int mode = 0;
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0, pc = '0, pn = '0;

  rs232_packet_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(16)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .rxd(rxd),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_cmd(out_cmd),
    .out_len(out_len),
    .chk_err(chk_err),
    .len_err(len_err),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Ready pattern: 0 always ready, 1 stalled, 2 toggling
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ~out_ready;
    endcase
  end

  // Monitor: collect beats, count pulses, check stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready)
        bq.push_back('{out_data, out_last, out_cmd, out_len});
      if (chk_err) chk_cnt++;
      if (len_err) len_cnt++;
      if (frame_err) frm_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid) vcnt++;
      if (pv && !pr && (out_data !== pd || out_last !== pl ||
          out_cmd !== pc || out_len !== pn || !out_valid))
        stab_err++;
    end
    pv = out_valid; pr = out_ready; pd = out_data;
    pl = out_last; pc = out_cmd; pn = out_len;
  end

  task automatic clear();
    bq.delete();
    chk_cnt = 0; len_cnt = 0; frm_cnt = 0; ovr_cnt = 0;
    vcnt = 0; stab_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (stop ? 4 : DIV) @(negedge clk);
  endtask

  task automatic send_good();
    send_byte(8'h7E, 1); send_byte(8'h05, 1); send_byte(8'h02, 1);
    send_byte(8'hA1, 1); send_byte(8'hB2, 1); send_byte(8'h14, 1);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (bq.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bq.size() < n) begin
      errors++;
      $display("FAIL beat_timeout: got %0d beats, need %0d", bq.size(), n);
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL valid_timeout: out_valid never rose");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_data, out_cmd, out_len} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outs: got %b %b %h %h %h, need zeros",
               out_valid, out_last, out_data, out_cmd, out_len);
    end
    checks++;
    if ({chk_err, len_err, frame_err, overrun} !== 4'd0) begin
      errors++;
      $display("FAIL reset_pulses: got %b, need 0000",
               {chk_err, len_err, frame_err, overrun});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good();
    clear();
    send_good();
    wait_beats(2);
    repeat (5) @(negedge clk);
    checks++;
    if (bq.size() != 2 || bq[0].d !== 8'hA1 || bq[0].l !== 1'b0 ||
        bq[0].c !== 8'h05 || bq[0].n !== 8'h02) begin
      errors++;
      $display("FAIL good_beat0: got n=%0d %h l%b c%h len%h, need A1 l0 c05 len02",
               bq.size(), bq[0].d, bq[0].l, bq[0].c, bq[0].n);
    end
    checks++;
    if (bq[1].d !== 8'hB2 || bq[1].l !== 1'b1) begin
      errors++;
      $display("FAIL good_beat1: got %h l%b, need B2 l1", bq[1].d, bq[1].l);
    end
    checks++;
    if (chk_cnt + len_cnt + frm_cnt + ovr_cnt != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_clean: got %0d pulses valid=%b, need 0 and 0",
               chk_cnt + len_cnt + frm_cnt + ovr_cnt, out_valid);
    end
  endtask

  task automatic test_bad_chk();
    clear();
    send_byte(8'h7E, 1); send_byte(8'h05, 1); send_byte(8'h02, 1);
    send_byte(8'hA1, 1); send_byte(8'hB2, 1); send_byte(8'h15, 1);
    repeat (20) @(negedge clk);
    checks++;
    if (chk_cnt != 1) begin
      errors++;
      $display("FAIL badchk_pulse: got %0d chk_err, need 1", chk_cnt);
    end
    checks++;
    if (vcnt != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL badchk_novalid: got %0d valid cycles, need 0", vcnt);
    end
    clear();
    send_good();
    wait_beats(2);
    checks++;
    if (bq[0].d !== 8'hA1 || bq[1].d !== 8'hB2 || bq[1].l !== 1'b1) begin
      errors++;
      $display("FAIL badchk_recover: got %h %h l%b, need A1 B2 l1",
               bq[0].d, bq[1].d, bq[1].l);
    end
  endtask

  task automatic test_len();
    clear();
    send_byte(8'h7E, 1); send_byte(8'h01, 1); send_byte(8'h11, 1);
    repeat (5) @(negedge clk);
    checks++;
    if (len_cnt != 1) begin
      errors++;
      $display("FAIL len_pulse: got %0d len_err, need 1", len_cnt);
    end
    clear();
    send_byte(8'h7E, 1); send_byte(8'h01, 1);
    send_byte(8'h00, 1); send_byte(8'h01, 1);
    wait_beats(1);
    repeat (5) @(negedge clk);
    checks++;
    if (bq.size() != 1 || bq[0].d !== 8'h00 || bq[0].l !== 1'b1 ||
        bq[0].c !== 8'h01 || bq[0].n !== 8'h00) begin
      errors++;
      $display("FAIL len_zero: got n=%0d %h l%b c%h len%h, need 1 00 l1 c01 len00",
               bq.size(), bq[0].d, bq[0].l, bq[0].c, bq[0].n);
    end
  endtask

  task automatic test_backpressure();
    clear();
    mode = 1;
    send_good();
    wait_valid();
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA1 || bq.size() != 0) begin
      errors++;
      $display("FAIL bp_hold: got v%b %h n=%0d, need v1 A1 n=0",
               out_valid, out_data, bq.size());
    end
    mode = 2;
    wait_beats(2);
    repeat (10) @(negedge clk);
    mode = 0;
    checks++;
    if (bq.size() != 2 || bq[0].d !== 8'hA1 || bq[1].d !== 8'hB2 ||
        bq[1].l !== 1'b1) begin
      errors++;
      $display("FAIL bp_beats: got n=%0d %h %h l%b, need 2 A1 B2 l1",
               bq.size(), bq[0].d, bq[1].d, bq[1].l);
    end
    checks++;
    if (out_valid !== 1'b0 || stab_err != 0) begin
      errors++;
      $display("FAIL bp_end: got v%b unstable=%0d, need v0 0", out_valid, stab_err);
    end
  endtask

  task automatic test_frame();
    clear();
    send_byte(8'h7E, 1);
    send_byte(8'h05, 0);
    send_byte(8'h02, 1); send_byte(8'hA1, 1);
    send_byte(8'hB2, 1); send_byte(8'h14, 1);
    repeat (10) @(negedge clk);
    checks++;
    if (frm_cnt != 1) begin
      errors++;
      $display("FAIL frame_pulse: got %0d frame_err, need 1", frm_cnt);
    end
    checks++;
    if (bq.size() != 0 || len_cnt != 0 || chk_cnt != 0) begin
      errors++;
      $display("FAIL frame_hunt: got n=%0d len=%0d chk=%0d, need 0 0 0",
               bq.size(), len_cnt, chk_cnt);
    end
  endtask

  task automatic test_overrun();
    clear();
    mode = 1;
    send_good();
    wait_valid();
    send_byte(8'h33, 1);
    checks++;
    if (ovr_cnt != 1 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
      errors++;
      $display("FAIL ovr_pulse: got %0d v%b %h, need 1 v1 A1",
               ovr_cnt, out_valid, out_data);
    end
    mode = 0;
    wait_beats(2);
    repeat (5) @(negedge clk);
    checks++;
    if (bq.size() != 2 || bq[0].d !== 8'hA1 || bq[1].d !== 8'hB2 ||
        stab_err != 0) begin
      errors++;
      $display("FAIL ovr_drain: got n=%0d %h %h unstable=%0d, need 2 A1 B2 0",
               bq.size(), bq[0].d, bq[1].d, stab_err);
    end
  endtask

  task automatic test_reset_mid();
    clear();
    send_byte(8'h7E, 1); send_byte(8'h05, 1);
    send_byte(8'h02, 1); send_byte(8'hA1, 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, out_cmd, out_len} !== 26'd0) begin
      errors++;
      $display("FAIL rstmid_outs: got v%b l%b %h c%h len%h, need zeros",
               out_valid, out_last, out_data, out_cmd, out_len);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear();
    send_good();
    wait_beats(2);
    checks++;
    if (bq[0].d !== 8'hA1 || bq[0].c !== 8'h05 || bq[1].d !== 8'hB2 ||
        bq[1].l !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_recover: got %h c%h %h l%b, need A1 c05 B2 l1",
               bq[0].d, bq[0].c, bq[1].d, bq[1].l);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_len();
    test_backpressure();
    test_frame();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
